// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types and helpers for the data-memory arbiter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    RLAST = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_e;

  // Size code 3 is treated as a word.
  function automatic logic [2:0] size_to_beats(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_beats = 3'd1;
      SZ_HALF: size_to_beats = 3'd2;
      default: size_to_beats = 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_assembler.sv
// ============================================================================
// byte_lane_assembler : collects read bytes into lanes and extends to 32 bits
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module byte_lane_assembler
  import dmem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_cap_en,
  input  logic [1:0]  i_cap_lane,
  input  logic [7:0]  i_byte,
  input  logic [2:0]  i_nbytes,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [3:0][7:0] r_lanes;
  logic            w_sign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lanes <= '0;
    end else if (i_clear) begin
      r_lanes <= '0;
    end else if (i_cap_en) begin
      r_lanes[i_cap_lane] <= i_byte;
    end
  end

  // Sign source is the top bit of the last byte of the transfer.
  always_comb begin
    w_sign = 1'b0;
    o_data = r_lanes;
    case (i_nbytes)
      3'd1: begin
        w_sign = r_lanes[0][7] & ~i_unsigned;
        o_data = {{24{w_sign}}, r_lanes[0]};
      end
      3'd2: begin
        w_sign = r_lanes[1][7] & ~i_unsigned;
        o_data = {{16{w_sign}}, r_lanes[1], r_lanes[0]};
      end
      default: o_data = r_lanes;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares the byte-wide data-memory bus between CPU and debug
// Optional macro DMEM_ARB_CPU_PRIO_EN : fixed CPU priority instead of round-robin
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TIE_FIRST = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic              dbg_unsigned,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e            r_state;
  req_e              r_grant;
  logic              r_we;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_nbeats;
  logic [1:0]        r_beat;
  logic              r_rd_pend;
  logic [1:0]        r_rd_lane;

  logic              w_any;
  req_e              w_sel;
  logic              w_xfer;
  logic              w_last;
  logic              w_in_ack;
  logic [31:0]       w_ext;

`ifndef DMEM_ARB_CPU_PRIO_EN
  req_e              r_last_grant;
`endif

  always_comb begin
    w_any = cpu_req | dbg_req;
`ifdef DMEM_ARB_CPU_PRIO_EN
    w_sel = cpu_req ? REQ_CPU : REQ_DBG;
`else
    if (cpu_req && dbg_req) begin
      w_sel = (r_last_grant == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else begin
      w_sel = cpu_req ? REQ_CPU : REQ_DBG;
    end
`endif
  end

  assign w_xfer   = (r_state == XFER);
  assign w_last   = ({1'b0, r_beat} == (r_nbeats - 3'd1));
  assign w_in_ack = (r_state == ACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_grant    <= REQ_CPU;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_nbeats   <= '0;
      r_beat     <= '0;
`ifndef DMEM_ARB_CPU_PRIO_EN
      r_last_grant <= (TIE_FIRST != 0) ? REQ_CPU : REQ_DBG;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant    <= w_sel;
            r_we       <= (w_sel == REQ_DBG) ? dbg_we       : cpu_we;
            r_unsigned <= (w_sel == REQ_DBG) ? dbg_unsigned : cpu_unsigned;
            r_addr     <= (w_sel == REQ_DBG) ? dbg_addr     : cpu_addr;
            r_wdata    <= (w_sel == REQ_DBG) ? dbg_wdata    : cpu_wdata;
            r_nbeats   <= size_to_beats((w_sel == REQ_DBG) ? dbg_size : cpu_size);
            r_beat     <= '0;
`ifndef DMEM_ARB_CPU_PRIO_EN
            r_last_grant <= w_sel;
`endif
            r_state    <= XFER;
          end
        end
        XFER: begin
          if (w_last) begin
            r_state <= r_we ? ACK : RLAST;
          end else begin
            r_beat <= r_beat + 2'd1;
          end
        end
        RLAST:   r_state <= ACK;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after its strobe, so the lane index trails the beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_pend <= 1'b0;
      r_rd_lane <= '0;
    end else begin
      r_rd_pend <= w_xfer & ~r_we;
      r_rd_lane <= r_beat;
    end
  end

  byte_lane_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .i_clear    ((r_state == IDLE) & w_any),
    .i_cap_en   (r_rd_pend),
    .i_cap_lane (r_rd_lane),
    .i_byte     (mem_rdata),
    .i_nbytes   (r_nbeats),
    .i_unsigned (r_unsigned),
    .o_data     (w_ext)
  );

  assign mem_write = w_xfer & r_we;
  assign mem_read  = w_xfer & ~r_we;
  assign mem_addr  = w_xfer ? (r_addr + ADDR_W'(r_beat)) : '0;
  assign mem_wdata = (w_xfer & r_we) ? r_wdata[{r_beat, 3'b000} +: 8] : '0;

  assign cpu_ack   = w_in_ack & (r_grant == REQ_CPU);
  assign dbg_ack   = w_in_ack & (r_grant == REQ_DBG);
  assign cpu_rdata = (cpu_ack & ~r_we) ? w_ext : '0;
  assign dbg_rdata = (dbg_ack & ~r_we) ? w_ext : '0;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : self-checking bench for dmem_arbiter with a byte-memory model
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

  localparam int TB_TIE_FIRST = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, cpu_unsigned = 0;
  logic [1:0]  cpu_size = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dbg_req = 0, dbg_we = 0, dbg_unsigned = 0;
  logic [1:0]  dbg_size = 0;
  logic [31:0] dbg_addr = 0, dbg_wdata = 0;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit both_seen = 0;

  bit [7:0] tbmem   [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];

  typedef struct {
    int          cyc;
    bit          we;
    logic [31:0] addr;
    logic [7:0]  data;
  } beat_t;
  beat_t beat_log[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .TIE_FIRST(TB_TIE_FIRST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size), .dbg_unsigned(dbg_unsigned),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte-wide memory: writes land at the edge, read data is returned the next cycle.
  always @(posedge clk) begin
    if (mem_write) tbmem[mem_addr] = mem_wdata;
  end
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= tbmem.exists(mem_addr) ? tbmem[mem_addr] : 8'h00;
  end
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_read && mem_write) both_seen = 1;
    if (mem_read || mem_write)
      beat_log.push_back('{cyc, mem_write, mem_addr, mem_write ? mem_wdata : 8'h00});
  end

  function automatic int beats_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext_model(input logic [31:0] raw, input int n, input bit uns);
    longint v;
    v = longint'(raw) & ((64'sd1 <<< (8 * n)) - 1);
    if (!uns && v[8*n-1]) v = v - (64'sd1 <<< (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input int n);
    logic [31:0] raw;
    logic [31:0] a;
    raw = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      raw[8*i +: 8] = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    end
    return raw;
  endfunction

  task automatic run_one(input bit dbg, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int drop_after,
                         output int lat, output logic [31:0] rd, output int stall_n,
                         output bit other_ack);
    lat = -1; rd = '0; stall_n = 0; other_ack = 0;
    @(posedge clk); #1;
    if (dbg) begin
      dbg_req = 1; dbg_we = we; dbg_size = sz; dbg_unsigned = uns; dbg_addr = addr; dbg_wdata = wd;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_size = sz; cpu_unsigned = uns; cpu_addr = addr; cpu_wdata = wd;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cpu_stall) stall_n++;
      if (dbg ? dbg_ack : cpu_ack) begin
        lat = k;
        rd = dbg ? dbg_rdata : cpu_rdata;
      end
      if (dbg ? cpu_ack : dbg_ack) other_ack = 1;
      @(posedge clk); #1;
      if (lat >= 0) break;
      if (k >= drop_after) begin
        if (dbg) dbg_req = 0; else cpu_req = 0;
      end
    end
    cpu_req = 0;
    dbg_req = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, cpu_rdata, cpu_stall, dbg_ack, dbg_rdata, mem_write, mem_read, mem_addr, mem_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: outputs not all zero (cpu_ack=%b mem_addr=%h mem_read=%b mem_write=%b)",
               cpu_ack, mem_addr, mem_read, mem_write);
    end
    reset = 1;
  endtask

  task automatic test_word_write();
    int lat, stl; logic [31:0] rd; bit oa;
    logic [31:0] wd;
    wd = 32'hDEADBEEF;
    beat_log.delete();
    run_one(0, 1, 2'd2, 0, 32'h100, wd, 99, lat, rd, stl, oa);
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL word_write_latency: got %0d want 5", lat); end
    n_cmp++;
    if (stl !== 5) begin n_bad++; $display("FAIL word_write_stall: stall cycles %0d want 5", stl); end
    n_cmp++;
    if (rd !== 32'h0 || oa) begin n_bad++; $display("FAIL word_write_rdata: rdata %h other_ack %b want 0/0", rd, oa); end
    n_cmp++;
    if (beat_log.size() != 4) begin
      n_bad++; $display("FAIL word_write_beats: %0d beats want 4", beat_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (!beat_log[i].we || beat_log[i].addr !== 32'h100 + 32'(i) || beat_log[i].data !== wd[8*i +: 8] ||
            beat_log[i].cyc != beat_log[0].cyc + i) begin
          n_bad++;
          $display("FAIL word_write_beat%0d: addr %h data %h we %b want addr %h data %h", i,
                   beat_log[i].addr, beat_log[i].data, beat_log[i].we, 32'h100 + 32'(i), wd[8*i +: 8]);
        end
      end
    end
  endtask

  task automatic test_half_read();
    int lat, stl; logic [31:0] rd; bit oa;
    tbmem[32'h200] = 8'h34; tbmem[32'h201] = 8'hF2;
    run_one(0, 0, 2'd1, 0, 32'h200, 32'h0, 99, lat, rd, stl, oa);
    n_cmp++;
    if (lat !== 4 || rd !== 32'hFFFFF234) begin
      n_bad++; $display("FAIL half_read_signed: lat %0d rdata %h want 4 FFFFF234", lat, rd);
    end
    run_one(0, 0, 2'd1, 1, 32'h200, 32'h0, 99, lat, rd, stl, oa);
    n_cmp++;
    if (lat !== 4 || rd !== 32'h0000F234) begin
      n_bad++; $display("FAIL half_read_unsigned: lat %0d rdata %h want 4 0000F234", lat, rd);
    end
  endtask

  task automatic test_round_robin();
    int got;
    bit last_dbg, exp_dbg, who;
    logic [31:0] rv;
    tbmem[32'h400] = 8'h81;
    tbmem[32'h500] = 8'h7F;
    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
    last_dbg = (TB_TIE_FIRST == 0);
    got = 0;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_size = 2'd0; cpu_unsigned = 0; cpu_addr = 32'h400;
    dbg_req = 1; dbg_we = 0; dbg_size = 2'd0; dbg_unsigned = 0; dbg_addr = 32'h500;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
        exp_dbg = 0;
`else
        exp_dbg = !last_dbg;
`endif
        last_dbg = exp_dbg;
        who = dbg_ack;
        rv = who ? dbg_rdata : cpu_rdata;
        n_cmp++;
        if (who !== exp_dbg || (cpu_ack && dbg_ack)) begin
          n_bad++; $display("FAIL rr_grant%0d: dbg_ack %b cpu_ack %b want dbg %b", got, dbg_ack, cpu_ack, exp_dbg);
        end
        n_cmp++;
        if (k != 3 + 4 * got) begin
          n_bad++; $display("FAIL rr_timing%0d: ack at cycle %0d want %0d", got, k, 3 + 4 * got);
        end
        n_cmp++;
        if (rv !== (who ? 32'h0000007F : 32'hFFFFFF81)) begin
          n_bad++; $display("FAIL rr_rdata%0d: rdata %h", got, rv);
        end
        got++;
      end
    end
    n_cmp++;
    if (got != 4) begin n_bad++; $display("FAIL rr_count: %0d acks want 4", got); end
    @(posedge clk); #1;
    cpu_req = 0; dbg_req = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_wrap();
    int lat, stl; logic [31:0] rd; bit oa;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
    beat_log.delete();
    run_one(0, 1, 2'd2, 0, 32'hFFFFFFFE, 32'h11223344, 99, lat, rd, stl, oa);
    n_cmp++;
    if (lat !== 5 || beat_log.size() != 4) begin
      n_bad++; $display("FAIL wrap_xfer: lat %0d beats %0d want 5 4", lat, beat_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (beat_log[i].addr !== exp_a[i]) begin
          n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, beat_log[i].addr, exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, stl; logic [31:0] rd; bit oa, saw_ack;
    for (int i = 0; i < 4; i++) tbmem[32'h600 + 32'(i)] = 8'hAA;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_size = 2'd2; cpu_unsigned = 0; cpu_addr = 32'h600; cpu_wdata = 32'h44332211;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (!mem_write || mem_addr !== 32'h602) begin
      n_bad++; $display("FAIL rstmid_beat2: mem_write %b addr %h want 1 00000602", mem_write, mem_addr);
    end
    #2 reset = 0;
    cpu_req = 0;
    #1;
    n_cmp++;
    if ({cpu_ack, cpu_rdata, dbg_ack, dbg_rdata, mem_write, mem_read, mem_addr, mem_wdata} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: mem_write %b mem_addr %h cpu_ack %b want all 0", mem_write, mem_addr, cpu_ack);
    end
    saw_ack = 0;
    repeat (3) begin @(negedge clk); if (cpu_ack || dbg_ack) saw_ack = 1; end
    reset = 1;
    n_cmp++;
    if (saw_ack) begin n_bad++; $display("FAIL rstmid_noack: ack seen %b want 0", saw_ack); end
    n_cmp++;
    if ({tbmem[32'h600], tbmem[32'h601], tbmem[32'h602], tbmem[32'h603]} !== 32'h1122AAAA) begin
      n_bad++; $display("FAIL rstmid_mem: bytes %h %h %h %h want 11 22 AA AA",
                        tbmem[32'h600], tbmem[32'h601], tbmem[32'h602], tbmem[32'h603]);
    end
    run_one(1, 1, 2'd0, 0, 32'h700, 32'h0000005A, 99, lat, rd, stl, oa);
    n_cmp++;
    if (lat !== 2 || tbmem[32'h700] !== 8'h5A || oa) begin
      n_bad++; $display("FAIL rstmid_dbgwrite: lat %0d byte %h other_ack %b want 2 5A 0", lat, tbmem[32'h700], oa);
    end
  endtask

  task automatic test_dbg_drop();
    int lat, stl; logic [31:0] rd; bit oa;
    logic [31:0] raw;
    raw = $urandom();
    for (int i = 0; i < 4; i++) begin
      tbmem[32'h800 + 32'(i)] = raw[8*i +: 8];
      ref_mem[32'h800 + 32'(i)] = raw[8*i +: 8];
    end
    run_one(1, 0, 2'd2, 0, 32'h800, 32'h0, 1, lat, rd, stl, oa);
    n_cmp++;
    if (lat !== 6 || rd !== ext_model(ref_read(32'h800, 4), 4, 0)) begin
      n_bad++; $display("FAIL dbg_drop: lat %0d rdata %h want 6 %h", lat, rd, raw);
    end
  endtask

  task automatic test_random();
    int lat, stl, n; logic [31:0] rd; bit oa;
    bit dbg, we, uns; logic [1:0] sz; logic [31:0] addr, wd, exp_rd, a;
    for (int i = 0; i < 16; i++) begin
      a = 32'h900 + 32'(i) * 4;  wd = $urandom();
      for (int j = 0; j < 4; j++) begin tbmem[a + 32'(j)] = wd[8*j +: 8]; ref_mem[a + 32'(j)] = wd[8*j +: 8]; end
    end
    for (int i = 0; i < 20; i++) begin
      a = 32'hFFFFFFF0 + 32'(i); wd = $urandom();
      tbmem[a] = wd[7:0]; ref_mem[a] = wd[7:0];
    end
    for (int t = 0; t < 40; t++) begin
      dbg = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                        : 32'h900 + 32'($urandom_range(0, 59));
      wd = $urandom();
      n = beats_of(sz);
      exp_rd = we ? 32'h0 : ext_model(ref_read(addr, n), n, uns);
      if (we) for (int j = 0; j < n; j++) ref_mem[addr + 32'(j)] = wd[8*j +: 8];
      run_one(dbg, we, sz, uns, addr, wd, 99, lat, rd, stl, oa);
      n_cmp++;
      if (lat !== (we ? n + 1 : n + 2) || rd !== exp_rd || oa) begin
        n_bad++;
        $display("FAIL rand%0d: dbg %b we %b sz %0d addr %h lat %0d rdata %h want lat %0d rdata %h other_ack %b",
                 t, dbg, we, sz, addr, lat, rd, we ? n + 1 : n + 2, exp_rd, oa);
      end
      n_cmp++;
      if (!dbg && stl != lat) begin
        n_bad++; $display("FAIL rand%0d_stall: stall cycles %0d want %0d", t, stl, lat);
      end
    end
    foreach (ref_mem[k]) begin
      n_cmp++;
      if (!tbmem.exists(k) || tbmem[k] !== ref_mem[k]) begin
        n_bad++; $display("FAIL rand_mem: addr %h got %h want %h", k, tbmem.exists(k) ? tbmem[k] : 8'h00, ref_mem[k]);
      end
    end
  endtask

  task automatic test_strobes();
    n_cmp++;
    if (both_seen) begin n_bad++; $display("FAIL strobe_exclusive: read and write together seen %b want 0", both_seen); end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_half_read();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_dbg_drop();
    test_random();
    test_strobes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-wide data-memory bus between two requesters: the CPU MEM stage and a debug/loader port.
- Serializes 1/2/4-byte transfers into byte beats in little-endian order.
- Assembles read bytes and sign- or zero-extends the result.
- Produces a CPU stall while the CPU request is outstanding.
- Sits between the pipeline MEM stage and the byte-wide data memory.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory bus.
- TIE_FIRST, 0, requester that wins the first tie after reset (0 = CPU, 1 = debug).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- cpu_req  in  1  CPU transfer request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- cpu_unsigned  in  1  read zero-extend (1) or sign-extend (0).
- cpu_addr  in  ADDR_W  base byte address.
- cpu_wdata  in  32  write data; low bytes used.
- cpu_rdata  out  32  extended read result; valid when cpu_ack = 1.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  combinational: cpu_req & ~cpu_ack.
- dbg_req, dbg_we, dbg_size, dbg_unsigned, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack: same as the cpu_* ports, for the debug/loader port.
- mem_write  out  1  byte write strobe.
- mem_read  out  1  byte read strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid the cycle after mem_read.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = ~TIE_FIRST, all internal registers cleared.
- Reset assertion mid-transfer: abort immediately, no ack; bytes already written stay written.
- States:
  - IDLE: sample requests and grant one.
  - XFER: issue beats.
  - RLAST: capture the last read byte.
  - ACK: pulse ack.
- IDLE:
  - One request: grant it.
  - Both requesting: grant the requester != last_grant.
  - On grant: latch we/size/unsigned/addr/wdata, set N = 1/2/4, beat index b = 0, update last_grant, go XFER.
- XFER, one beat per cycle:
  - mem_addr = base + b, modulo 2^ADDR_W (wraps past the top address).
  - Write beats: mem_write = 1, mem_wdata = wdata[8b+7:8b].
  - Read beats: mem_read = 1; the byte for beat b is captured into byte lane b in cycle b+1.
  - After beat N-1: write → ACK; read → RLAST.
- RLAST: capture the final byte; go ACK. No memory strobes.
- ACK:
  - Pulse ack for the granted requester; rdata is registered and stable that cycle; go IDLE.
  - rdata for reads = bytes extended from bit 8N-1 (sign if unsigned = 0, else zero). For writes, rdata = 0.
  - Non-granted ack and rdata stay 0.
- Latency from the cycle the request is seen in IDLE:
  - Writes: ack at cycle N+1 (byte 2, half 3, word 5).
  - Reads: ack at cycle N+2 (byte 3, half 4, word 6).
- Requester rules:
  - Request fields must be held stable until ack; changes mid-transfer are ignored because fields are latched.
  - req dropping mid-transfer does not abort; ack still pulses.
  - A request seen in ACK is not granted until the next IDLE cycle (one dead cycle between transfers).
- Misaligned base addresses are legal; no alignment check.
- mem_read and mem_write are never asserted together.

Optional Feature:
- Macro DMEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority; the CPU always wins a tie in IDLE; last_grant is unused and TIE_FIRST is ignored.
- Undefined: round-robin tie-break as described in Behaviour.

Decomposition:
- Package dmem_arb_pkg holds:
  - size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state enum (IDLE, XFER, RLAST, ACK);
  - requester id enum (REQ_CPU, REQ_DBG);
  - function size_to_beats.
- Sub-module byte_lane_assembler: captures mem_rdata into lane b and performs extension from N bytes to 32 bits.
- The FSM and arbitration stay in dmem_arbiter.

Test Plan:
- CPU word write, addr 0x100, wdata 0xDEADBEEF.
  - Beats 0x100..0x103 carry EF, BE, AD, DE on consecutive cycles; cpu_ack at cycle 5; cpu_stall high for cycles 0–4.
- CPU half read, signed, addr 0x200, memory bytes 0x34, 0xF2.
  - cpu_rdata = 0xFFFFF234 at cycle 4.
  - Same read with unsigned = 1: cpu_rdata = 0x0000F234.
- Both requesters assert byte reads every transfer after reset.
  - Grants alternate CPU, DBG, CPU, DBG.
  - With DMEM_ARB_CPU_PRIO_EN: always CPU while cpu_req is held.
- Wrap case: word write at addr 0xFFFFFFFE → mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset asserted (reset = 0) during beat 2 of a word write.
  - All outputs 0 immediately; no ack.
  - After release, a new debug byte write completes with dbg_ack at cycle 2.
- Debug word read with dbg_req dropped after cycle 1 → transfer completes; dbg_ack still pulses at cycle 6.
